lsu_wb: RTL and testbench

LSU_WB -- requirements
Module: lsu_wb

---
 rtl/lsu_wb.sv | 196 +++++++++++++++++++
 tb/tb_lsu_wb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_wb.sv
// rtl/lsu_wb.sv - load/store unit bridging a pipeline request port to a Wishbone classic master
//
// Purpose: accepts one load or store at a time, checks natural alignment,
// runs a single Wishbone classic cycle with byte lanes derived from the
// address offset, and reports completion with load data or a fault cause.
//
// Ports:
//   clk_i, reset_i                 clock (rising edge), async active-high reset
//   valid_i / ready_o              request handshake (ready only when idle)
//   we_i, size_i, signed_i         store/load, access size, load sign extension
//   addr_i, dat_i                  byte address, right-justified store data
//   done_o, dat_o, fault_o, cause_o   one-cycle completion with result
//   wb_*                           Wishbone classic master interface

module lsu_wb #(
    parameter int XLEN = 64,
    parameter int TO_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   dat_i,
    output logic              done_o,
    output logic [XLEN-1:0]   dat_o,
    output logic              fault_o,
    output logic [1:0]        cause_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [XLEN-1:0]   wb_adr_o,
    output logic [XLEN-1:0]   wb_dat_o,
    output logic [XLEN/8-1:0] wb_sel_o,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic [XLEN-1:0]   wb_dat_i
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic [XLEN-1:0]   adr_q, adr_d;
    logic [XLEN-1:0]   wdat_q, wdat_d;
    logic [NB-1:0]     sel_q, sel_d;
    logic [XLEN-1:0]   dat_q, dat_d;
    logic [1:0]        cause_q, cause_d;

    logic              misaligned;
    logic [OFFW-1:0]   off_n;
    logic [NB-1:0]     sel_n;
    int                nbytes;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   keep;
    logic              sbit;
    logic [XLEN-1:0]   load_val;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            off_q    <= '0;
            adr_q    <= '0;
            wdat_q   <= '0;
            sel_q    <= '0;
            dat_q    <= '0;
            cause_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            off_q    <= off_d;
            adr_q    <= adr_d;
            wdat_q   <= wdat_d;
            sel_q    <= sel_d;
            dat_q    <= dat_d;
            cause_q  <= cause_d;
        end
    end

    // Request decode: alignment check and byte-lane mask from the live inputs.
    always_comb begin
        off_n  = addr_i[OFFW-1:0];
        nbytes = 1 << size_i;
        case (size_i)
            2'b01:   misaligned = addr_i[0];
            2'b10:   misaligned = |addr_i[1:0];
            2'b11:   misaligned = (XLEN == 32) || (|addr_i[2:0]);
            default: misaligned = 1'b0;
        endcase
        for (int i = 0; i < NB; i++) begin
            sel_n[i] = (i >= int'(off_n)) && (i < int'(off_n) + nbytes);
        end
    end

    // Load result: shift the addressed lanes down, keep the access width,
    // and fill the upper bits with the sign bit when requested.
    always_comb begin
        shifted = wb_dat_i >> {off_q, 3'b000};
        case (size_q)
            2'b00:   begin keep = XLEN'(8'hFF);          sbit = shifted[7];  end
            2'b01:   begin keep = XLEN'(16'hFFFF);       sbit = shifted[15]; end
            2'b10:   begin keep = XLEN'(32'hFFFF_FFFF);  sbit = shifted[31]; end
            default: begin keep = '1;                    sbit = 1'b0;        end
        endcase
        load_val = (shifted & keep) | ({XLEN{signed_q & sbit}} & ~keep);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        off_d    = off_q;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        sel_d    = sel_q;
        dat_d    = dat_q;
        cause_d  = cause_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    dat_d = '0;
                    if (misaligned) begin
                        state_d = S_RESP;
                        cause_d = 2'b01;
                    end else begin
                        state_d  = S_BUS;
                        cause_d  = 2'b00;
                        cnt_d    = '0;
                        we_d     = we_i;
                        size_d   = size_i;
                        signed_d = signed_i;
                        off_d    = off_n;
                        adr_d    = {addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
                        wdat_d   = dat_i << {off_n, 3'b000};
                        sel_d    = sel_n;
                    end
                end
            end
            S_BUS: begin
                if (wb_err_i) begin
                    state_d = S_RESP;
                    cause_d = 2'b10;
                    dat_d   = '0;
                end else if (wb_ack_i) begin
                    state_d = S_RESP;
                    cause_d = 2'b00;
                    dat_d   = we_q ? '0 : load_val;
                end else if (cnt_q == {TO_W{1'b1}}) begin
                    state_d = S_RESP;
                    cause_d = 2'b11;
                    dat_d   = '0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready_o  = (state_q == S_IDLE);
    assign wb_cyc_o = (state_q == S_BUS);
    assign wb_stb_o = (state_q == S_BUS);
    assign wb_we_o  = (state_q == S_BUS) && we_q;
    assign wb_sel_o = (state_q == S_BUS) ? sel_q : '0;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = wdat_q;
    assign done_o   = (state_q == S_RESP);
    assign cause_o  = (state_q == S_RESP) ? cause_q : 2'b00;
    assign fault_o  = (state_q == S_RESP) && (cause_q != 2'b00);
    assign dat_o    = dat_q;

endmodule

// File: tb/tb_lsu_wb.sv
// tb/tb_lsu_wb.sv - self-checking bench for lsu_wb with a byte-level reference model

module tb_lsu_wb;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        valid_i;
    logic        ready_o;
    logic        we_i;
    logic [1:0]  size_i;
    logic        signed_i;
    logic [63:0] addr_i;
    logic [63:0] dat_i;
    logic        done_o;
    logic [63:0] dat_o;
    logic        fault_o;
    logic [1:0]  cause_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [63:0] wb_adr_o;
    logic [63:0] wb_dat_o;
    logic [7:0]  wb_sel_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic [63:0] wb_dat_i;

    int checks = 0;
    int errors = 0;

    lsu_wb #(.XLEN(64), .TO_W(4)) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .we_i     (we_i),
        .size_i   (size_i),
        .signed_i (signed_i),
        .addr_i   (addr_i),
        .dat_i    (dat_i),
        .done_o   (done_o),
        .dat_o    (dat_o),
        .fault_o  (fault_o),
        .cause_o  (cause_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .wb_dat_i (wb_dat_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-lane view of a naturally aligned access on a 64-bit bus.
    function automatic logic [7:0] m_sel(input logic [63:0] a, input logic [1:0] sz);
        int n = 1 << sz;
        int off = int'(a % 64'd8);
        logic [7:0] s = 8'h00;
        for (int b = 0; b < 8; b++) if (b >= off && b < off + n) s[b] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [63:0] a,
                                           input logic [1:0] sz, input logic sg);
        int n = 1 << sz;
        int off = int'(a % 64'd8);
        logic [63:0] v = 64'd0;
        for (int b = 0; b < n; b++) v[8*b +: 8] = rd[8*(off+b) +: 8];
        if (sg && n < 8 && v[8*n-1]) for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    // kind: 0 ack, 1 err, 2 err+ack together, 3 no response (timeout)
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [63:0] a, input logic [63:0] d, input logic [63:0] rd,
                          input int kind, input int dly);
        logic        mis = (a % (64'd1 << sz)) != 64'd0;
        logic [63:0] exp_dat;
        logic [1:0]  exp_cause;
        bit          hit;
        valid_i = 1'b1; we_i = we; size_i = sz; signed_i = sg; addr_i = a; dat_i = d;
        chk("ready_idle", {63'd0, ready_o}, 64'd1);
        tick();
        valid_i = 1'b0;
        addr_i = {$urandom, $urandom};
        dat_i  = {$urandom, $urandom};
        if (mis) begin
            exp_cause = 2'b01;
            exp_dat   = 64'd0;
        end else begin
            hit = 1'b0;
            for (int k = 0; k < 16; k++) begin
                chk("bus_cyc", {63'd0, wb_cyc_o}, 64'd1);
                chk("bus_stb", {63'd0, wb_stb_o}, 64'd1);
                chk("bus_we", {63'd0, wb_we_o}, {63'd0, we});
                chk("bus_adr", wb_adr_o, a - (a % 64'd8));
                chk("bus_sel", {56'd0, wb_sel_o}, {56'd0, m_sel(a, sz)});
                chk("bus_wdat", wb_dat_o, d << (8 * (a % 64'd8)));
                chk("bus_done", {63'd0, done_o}, 64'd0);
                chk("bus_ready", {63'd0, ready_o}, 64'd0);
                wb_dat_i = {$urandom, $urandom};
                if (kind != 3 && k == dly) begin
                    wb_dat_i = rd;
                    wb_ack_i = (kind == 0 || kind == 2);
                    wb_err_i = (kind == 1 || kind == 2);
                    hit = 1'b1;
                end
                tick();
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                if (hit) break;
            end
            case (kind)
                0:       exp_cause = 2'b00;
                3:       exp_cause = 2'b11;
                default: exp_cause = 2'b10;
            endcase
            exp_dat = (kind == 0 && !we) ? m_load(rd, a, sz, sg) : 64'd0;
        end
        chk("resp_done", {63'd0, done_o}, 64'd1);
        chk("resp_cyc", {63'd0, wb_cyc_o}, 64'd0);
        chk("resp_cause", {62'd0, cause_o}, {62'd0, exp_cause});
        chk("resp_fault", {63'd0, fault_o}, {63'd0, exp_cause != 2'b00});
        chk("resp_dat", dat_o, exp_dat);
        chk("resp_ready", {63'd0, ready_o}, 64'd0);
        // A request offered during the response cycle must not be taken.
        valid_i = 1'b1; we_i = 1'b0; size_i = 2'b00; addr_i = 64'h2000;
        tick();
        valid_i = 1'b0;
        chk("post_done", {63'd0, done_o}, 64'd0);
        chk("post_ready", {63'd0, ready_o}, 64'd1);
        chk("post_cyc", {63'd0, wb_cyc_o}, 64'd0);
        chk("post_cause", {62'd0, cause_o}, 64'd0);
    endtask

    initial begin
        reset_i = 1'b1; valid_i = 1'b0; we_i = 1'b0; size_i = 2'b00; signed_i = 1'b0;
        addr_i = 64'd0; dat_i = 64'd0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 64'd0;
        tick();
        tick();
        chk("rst_ready", {63'd0, ready_o}, 64'd1);
        chk("rst_cyc", {63'd0, wb_cyc_o}, 64'd0);
        chk("rst_stb", {63'd0, wb_stb_o}, 64'd0);
        chk("rst_we", {63'd0, wb_we_o}, 64'd0);
        chk("rst_sel", {56'd0, wb_sel_o}, 64'd0);
        chk("rst_done", {63'd0, done_o}, 64'd0);
        chk("rst_fault", {63'd0, fault_o}, 64'd0);
        chk("rst_cause", {62'd0, cause_o}, 64'd0);
        chk("rst_dat", dat_o, 64'd0);
        reset_i = 1'b0;
        tick();

        // Store half 0xBEEF at 0x1006, ack on the third bus cycle.
        do_req(1'b1, 2'b01, 1'b0, 64'h1006, 64'h0000_0000_0000_BEEF, 64'd0, 0, 2);
        // Signed then unsigned byte load at 0x1003.
        do_req(1'b0, 2'b00, 1'b1, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
        do_req(1'b0, 2'b00, 1'b0, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 1);
        // Misaligned word load.
        do_req(1'b0, 2'b10, 1'b0, 64'h1002, 64'd0, 64'd0, 0, 0);
        // Error and ack in the same cycle.
        do_req(1'b0, 2'b11, 1'b0, 64'h1008, 64'd0, 64'h1234_5678_9ABC_DEF0, 2, 1);
        // No slave response: timeout after 16 bus cycles.
        do_req(1'b0, 2'b10, 1'b1, 64'h1004, 64'd0, 64'd0, 3, 0);
        // Aligned dword and signed half/word loads.
        do_req(1'b0, 2'b11, 1'b1, 64'h1010, 64'd0, 64'hF123_4567_89AB_CDEF, 0, 0);
        do_req(1'b0, 2'b01, 1'b1, 64'h1012, 64'd0, 64'h0000_0000_9876_0000, 0, 3);
        do_req(1'b0, 2'b10, 1'b1, 64'h1014, 64'd0, 64'h8765_4321_0000_0000, 0, 0);

        // Reset on the second bus cycle abandons the transfer.
        valid_i = 1'b1; we_i = 1'b0; size_i = 2'b10; signed_i = 1'b0; addr_i = 64'h1020;
        tick();
        valid_i = 1'b0;
        chk("rb_cyc1", {63'd0, wb_cyc_o}, 64'd1);
        tick();
        chk("rb_cyc2", {63'd0, wb_cyc_o}, 64'd1);
        reset_i = 1'b1;
        #1;
        chk("rb_async_cyc", {63'd0, wb_cyc_o}, 64'd0);
        chk("rb_async_stb", {63'd0, wb_stb_o}, 64'd0);
        chk("rb_async_done", {63'd0, done_o}, 64'd0);
        #2;
        reset_i = 1'b0;
        tick();
        chk("rb_ready", {63'd0, ready_o}, 64'd1);
        chk("rb_done", {63'd0, done_o}, 64'd0);
        tick();
        chk("rb_done2", {63'd0, done_o}, 64'd0);
        chk("rb_cyc3", {63'd0, wb_cyc_o}, 64'd0);

        // Randomized transactions against the reference model.
        for (int t = 0; t < 60; t++) begin
            int r;
            int kind;
            r = int'($urandom % 8);
            kind = (r < 5) ? 0 : (r == 5) ? 1 : (r == 6) ? 2 : 3;
            do_req(1'($urandom), 2'($urandom), 1'($urandom),
                   64'h1000 + 64'($urandom_range(0, 63)),
                   {$urandom, $urandom}, {$urandom, $urandom},
                   kind, int'($urandom_range(0, 5)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
